arb3_grant_ctrl: RTL

Grant controller that shares one downstream resource among three requesters using the same request/index convention as the 3-to-2 priority encoder: request bit 2 is highest priority in fixed mode. The block sits between the requester agents and the shared resource. It arbitrates registered requests and holds a one-hot grant until the owner releases the resource. A watchdog forcibly revokes any grant held too long. Fixed-priority and round-robin modes are selectable by parameter.

---
 rtl/arb3_grant_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/arb3_grant_ctrl.sv
// Three-requester grant controller: registered one-hot grant, held until release,
// with fixed-priority or round-robin arbitration and a hold-time watchdog.
module arb3_grant_ctrl #(
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Watchdog fires on the MAX_HOLD-th grant cycle, i.e. when the counter reads MAX_HOLD-1.
    localparam bit         WD_EN    = (MAX_HOLD != 32'd0);
    localparam logic [7:0] WD_LIMIT = (MAX_HOLD == 32'd0) ? 8'd0 : 8'(MAX_HOLD - 32'd1);

    state_e     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [1:0] win_s;
    logic       wd_hit_s;
    logic       rel_s;

    function automatic logic [1:0] dec3(input logic [1:0] x);
        return (x == 2'd0) ? 2'd2 : (x - 2'd1);
    endfunction

    function automatic logic [1:0] pick_fixed(input logic [2:0] r);
        logic [1:0] w;
        if (r[2]) begin
            w = 2'd2;
        end else if (r[1]) begin
            w = 2'd1;
        end else begin
            w = 2'd0;
        end
        return w;
    endfunction

    // Descending search starting at (last+2) mod 3, so the last winner is tried last.
    function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] w;
        case (last)
            2'd0:    c0 = 2'd2;
            2'd1:    c0 = 2'd0;
            2'd2:    c0 = 2'd1;
            default: c0 = 2'd2;
        endcase
        c1 = dec3(c0);
        c2 = dec3(c1);
        if (r[c0]) begin
            w = c0;
        end else if (r[c1]) begin
            w = c1;
        end else begin
            w = c2;
        end
        return w;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        win_s       = (RR_MODE != 32'd0) ? pick_rr(req, last_q) : pick_fixed(req);
        wd_hit_s    = WD_EN && (hold_cnt_q == WD_LIMIT);
        rel_s       = done || !req[owner_q];
        case (state_q)
            ST_IDLE: begin
                if (req != 3'b000) begin
                    state_d     = ST_GRANT;
                    gnt_d       = 3'b001 << win_s;
                    gnt_id_d    = win_s;
                    gnt_valid_d = 1'b1;
                    owner_d     = win_s;
                    last_d      = win_s;
                    hold_cnt_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (rel_s || wd_hit_s) begin
                    state_d     = ST_RELEASE;
                    gnt_d       = 3'b000;
                    gnt_id_d    = 2'd0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = wd_hit_s && !rel_s;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            ST_RELEASE: begin
                state_d     = ST_IDLE;
                gnt_d       = 3'b000;
                gnt_id_d    = 2'd0;
                gnt_valid_d = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 3'b000;
                gnt_id_d    = 2'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 3'b000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 8'd0;
            owner_q     <= 2'd0;
            last_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
